// File: rtl/aspsa_scheduler.sv
// Iteration sequencer for the A-SPSA loop: paces iterations, opens one error window per
// perturbation, gates shadow-bank swaps to frame boundaries, anneals on drift, watchdogs stalls.
module aspsa_scheduler #(
    parameter int unsigned NUM_WEIGHTS   = 1170,
    parameter int unsigned ITER_PERIOD   = 4096,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned TIMEOUT       = 65535,
    parameter int unsigned TEMP_WIDTH    = 8,
    parameter int unsigned TEMP_DELTA    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fault_clr,
    input  logic [15:0]           err_in,
    input  logic                  err_valid_in,
    input  logic [TEMP_WIDTH-1:0] temp_in,
    input  logic                  temp_valid,
    input  logic                  frame_boundary,
    output logic                  eng_enable,
    output logic [15:0]           eng_error,
    output logic                  eng_error_valid,
    input  logic                  eng_busy,
    input  logic                  eng_update_req,
    output logic                  eng_update_ack,
    output logic                  eng_anneal_reset,
    output logic                  swap_req,
    input  logic                  swap_ack,
    output logic [15:0]           iter_count,
    output logic                  fault,
    output logic [3:0]            state_dbg
);

    localparam int unsigned SETTLE_TOTAL = NUM_WEIGHTS + 2 + SETTLE_CYCLES;
    localparam int unsigned TMR_MAX      = (TIMEOUT > SETTLE_TOTAL) ? TIMEOUT : SETTLE_TOTAL;
    localparam int unsigned TW           = $clog2(TMR_MAX + 1);
    localparam int unsigned PW           = $clog2(ITER_PERIOD + 1);
    localparam int unsigned DW           = TEMP_WIDTH + 1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        GAP        = 4'd1,
        MEAS0      = 4'd2,
        SETTLE1    = 4'd3,
        MEAS1      = 4'd4,
        SETTLE2    = 4'd5,
        MEAS2      = 4'd6,
        WAIT_REQ   = 4'd7,
        WAIT_FRAME = 4'd8,
        SWAP       = 4'd9,
        ACK        = 4'd10,
        DRAIN      = 4'd11,
        FAULT      = 4'd12
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] tmr;
    logic [PW-1:0] pcnt;
    logic          first_iter;
    logic          watched;
    logic          timed_out;
    logic          settled;
    logic          period_done;
    logic          in_meas;

    logic [TEMP_WIDTH-1:0] temp_ref;
    logic                  ref_valid;
    logic [DW-1:0]         tdiff;
    logic [DW-1:0]         tmag;

    assign state_dbg = state;

    // One timer serves both the settle delay and the watchdog; it restarts on every state change.
    // Forward progress wins over a watchdog expiry landing on the same cycle.
    always_comb begin
        watched     = state inside {MEAS0, MEAS1, MEAS2, WAIT_REQ, WAIT_FRAME, SWAP, DRAIN};
        in_meas     = state inside {MEAS0, MEAS1, MEAS2};
        timed_out   = watched && (tmr >= TW'(TIMEOUT - 1));
        settled     = tmr >= TW'(SETTLE_TOTAL - 1);
        period_done = first_iter || (pcnt >= PW'(ITER_PERIOD - 1));
        nxt         = state;
        case (state)
            IDLE:       if (enable && !eng_busy) nxt = GAP;
            GAP:        if (!enable) nxt = IDLE; else if (period_done) nxt = MEAS0;
            MEAS0:      if (err_valid_in) nxt = SETTLE1; else if (timed_out) nxt = FAULT;
            SETTLE1:    if (settled) nxt = MEAS1;
            MEAS1:      if (err_valid_in) nxt = SETTLE2; else if (timed_out) nxt = FAULT;
            SETTLE2:    if (settled) nxt = MEAS2;
            MEAS2:      if (err_valid_in) nxt = WAIT_REQ; else if (timed_out) nxt = FAULT;
            WAIT_REQ:   if (eng_update_req) nxt = WAIT_FRAME; else if (timed_out) nxt = FAULT;
            WAIT_FRAME: if (frame_boundary) nxt = SWAP; else if (timed_out) nxt = FAULT;
            SWAP:       if (swap_ack) nxt = ACK; else if (timed_out) nxt = FAULT;
            ACK:        nxt = DRAIN;
            DRAIN:      if (!eng_busy) nxt = enable ? GAP : IDLE; else if (timed_out) nxt = FAULT;
            FAULT:      if (fault_clr && !eng_busy) nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_dbg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tmr             <= '0;
            pcnt            <= '0;
            first_iter      <= 1'b0;
            eng_enable      <= 1'b0;
            eng_error       <= '0;
            eng_error_valid <= 1'b0;
            eng_update_ack  <= 1'b0;
            swap_req        <= 1'b0;
            iter_count      <= '0;
            fault           <= 1'b0;
        end else begin
            state           <= nxt;
            eng_enable      <= !(nxt inside {IDLE, FAULT});
            eng_update_ack  <= (nxt == ACK);
            swap_req        <= (nxt == SWAP);
            fault           <= (nxt == FAULT);
            eng_error_valid <= 1'b0;
            if (in_meas && err_valid_in) begin
                eng_error       <= err_in;
                eng_error_valid <= 1'b1;
            end
            if (state == DRAIN && !eng_busy) begin
                iter_count <= iter_count + 16'd1;
            end

            if (nxt != state) tmr <= '0;
            else if (tmr != TW'(TMR_MAX)) tmr <= tmr + 1'b1;

            // Period is measured start-to-start, so it restarts when MEAS0 is entered.
            if ((state == GAP && nxt == MEAS0) || (state == IDLE && nxt == GAP)) pcnt <= '0;
            else if (pcnt != PW'(ITER_PERIOD - 1)) pcnt <= pcnt + 1'b1;

            if (state == IDLE && nxt == GAP) first_iter <= 1'b1;
            else if (state == GAP && nxt != GAP) first_iter <= 1'b0;
        end
    end

    always_comb begin
        tdiff = {temp_in[TEMP_WIDTH-1], temp_in} - {temp_ref[TEMP_WIDTH-1], temp_ref};
        tmag  = tdiff[DW-1] ? (~tdiff + 1'b1) : tdiff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_ref         <= '0;
            ref_valid        <= 1'b0;
            eng_anneal_reset <= 1'b0;
        end else begin
            eng_anneal_reset <= 1'b0;
            if (temp_valid) begin
                if (!ref_valid) begin
                    temp_ref  <= temp_in;
                    ref_valid <= 1'b1;
                end else if (tmag >= DW'(TEMP_DELTA)) begin
                    temp_ref         <= temp_in;
                    eng_anneal_reset <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/aspsa_scheduler.md
Name: aspsa_scheduler

Overview:
- Iteration sequencer between error_metric, aspsa_engine and the shadow weight memory.
- Paces A-SPSA iterations and opens a measurement window per perturbation after a settle delay.
- Forwards exactly one error sample per window to the engine.
- Gates the engine's shadow-sync request to a frame boundary; issues anneal resets on temperature drift; watchdog faults on stalls.

Parameters:
NUM_WEIGHTS, 1170, weights perturbed per phase by the engine
ITER_PERIOD, 4096, minimum clk cycles between iteration starts (start-to-start)
SETTLE_CYCLES, 64, PA/feedback settle cycles after a perturbation pass completes
TIMEOUT, 65535, watchdog limit in cycles for any wait state
TEMP_WIDTH, 8, signed temperature width
TEMP_DELTA, 8, drift magnitude that triggers anneal reset

Ports:
clk  in  1  system clock (1 MHz)
rst  in  1  synchronous, active-high reset
enable  in  1  adaptation enable
fault_clr  in  1  clears sticky fault
err_in  in  16  signed Q8.8 error from error_metric
err_valid_in  in  1  err_in valid strobe
temp_in  in  TEMP_WIDTH  signed die temperature
temp_valid  in  1  temp_in strobe
frame_boundary  in  1  one-cycle frame-start pulse
eng_enable  out  1  to aspsa_engine.enable
eng_error  out  16  to aspsa_engine.error_metric
eng_error_valid  out  1  to aspsa_engine.error_valid
eng_busy  in  1  from aspsa_engine.busy
eng_update_req  in  1  from aspsa_engine.update_req
eng_update_ack  out  1  to aspsa_engine.update_ack
eng_anneal_reset  out  1  to aspsa_engine.anneal_reset
swap_req  out  1  shadow bank swap request
swap_ack  in  1  shadow bank swap done
iter_count  out  16  completed iterations, wraps at 16'hFFFF->0
fault  out  1  sticky watchdog fault
state_dbg  out  4  current state encoding

Behaviour:
- One clock; rst is synchronous, active-high. On rst, all outputs go to 0, state=IDLE, counters cleared, temperature reference invalid.
- States, in encoding order 0..12:
  - IDLE
  - GAP
  - MEAS0
  - SETTLE1
  - MEAS1
  - SETTLE2
  - MEAS2
  - WAIT_REQ
  - WAIT_FRAME
  - SWAP
  - ACK
  - DRAIN
  - FAULT
- eng_enable=1 in every state except IDLE and FAULT.
- IDLE -> GAP when enable=1 and eng_busy=0. Period counter starts at 0.
- GAP: counts. -> MEAS0 when count >= ITER_PERIOD-1 or on the first iteration after IDLE. -> IDLE if enable=0.
- MEASn, measurement windows:
  - The first err_valid_in seen while in the window is registered to eng_error.
  - eng_error_valid pulses 1 cycle later, single cycle.
  - Samples before the window opens are ignored.
  - Transitions: MEAS0 -> SETTLE1, MEAS1 -> SETTLE2, MEAS2 -> WAIT_REQ.
- SETTLE1/2: wait NUM_WEIGHTS+2+SETTLE_CYCLES cycles (perturbation pass plus settle), then go to the next MEAS.
- WAIT_REQ -> WAIT_FRAME on eng_update_req=1.
- WAIT_FRAME -> SWAP on frame_boundary. swap_req rises on SWAP entry and holds until swap_ack.
- SWAP: on swap_ack, drop swap_req next cycle and go -> ACK.
- ACK: eng_update_ack=1 for exactly 1 cycle, then -> DRAIN.
- DRAIN: when eng_busy=0, iter_count+1, then -> GAP if enable else IDLE.
- enable=0 mid-iteration (MEAS0 through DRAIN): the iteration completes normally, since the engine cannot abort. Only the DRAIN exit target changes.
- Watchdog:
  - Counter resets on each state entry.
  - Runs in MEASn, WAIT_REQ, WAIT_FRAME, SWAP and DRAIN.
  - On reaching TIMEOUT: -> FAULT, fault=1, swap_req=0, eng_error_valid never asserted.
  - FAULT -> IDLE on fault_clr and eng_busy=0. fault clears the same cycle.
- Temperature reference:
  - The first temp_valid after reset loads temp_ref and sets it valid; no pulse.
  - Later temp_valid: compute |temp_in - temp_ref| at TEMP_WIDTH+1 bits, signed. If >= TEMP_DELTA, eng_anneal_reset pulses 1 cycle (registered) and temp_ref <= temp_in.
  - Operates in all states, including mid-iteration.
- Simultaneous events:
  - err_valid_in on the window-open cycle is accepted.
  - A frame_boundary and eng_update_req arriving in the same cycle waits for the next frame_boundary.
  - swap_ack arriving before swap_req is ignored.
  - rst overrides all.

Test Plan:
1. ITER_PERIOD=200, SETTLE=4, NUM_WEIGHTS=8, engine model honours req/ack; enable=1 with err_valid_in every 5 cycles -> exactly 3 eng_error_valid pulses per iteration, swap_req held until swap_ack, one 1-cycle eng_update_ack, iter_count 0->1->2, starts 200 cycles apart.
2. err_in=16'h0100 strobed during SETTLE1, then 16'h0200 in MEAS1 -> the sole MEAS1 forward carries 16'h0200, 1 cycle after the strobe.
3. eng_update_req high, frame_boundary delayed 50 cycles -> swap_req rises the cycle after frame_boundary; no eng_update_ack before swap_ack.
4. Withhold err_valid_in with TIMEOUT=100 -> fault=1 and state_dbg=12 exactly 100 cycles into MEAS0; fault_clr with eng_busy=0 -> IDLE, fault=0.
5. temp_valid at 25, then 30, then 34 (TEMP_DELTA=8) -> no pulse, no pulse, one anneal pulse. Then -10 -> pulse, and the reference becomes -10.
6. enable dropped in SETTLE2 -> iteration completes, iter_count increments, returns to IDLE with eng_enable=0. rst asserted in SWAP -> all outputs 0 next cycle.
